test_tx_gen: RTL and testbench
==============================

Name: test_tx_gen

Overview:
Parametrised successor of the team's fixed-width test packet source. Generates framed test packets (valid/sof/eof) toward the MAC TX path with these additions:
- selectable payload pattern;
- downstream backpressure (ready);
- a programmable packet count;
- status outputs.

It sits in the BFD test harness in front of the MAC TX interface. The matching RX checker regenerates the same pattern per packet.

Parameters:
TEST_DATA_WIDTH, 32, data bus width; legal 8..64, multiple of 8.
LFSR_SEED, 32'h55AA55AA, LFSR value loaded at every packet start; must be nonzero.
CNT_WIDTH, 16, width of pkt_size, pause_size, pkt_num, pkt_cnt.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active high.
start  in  1  level; run request, sampled in IDLE and at packet boundaries.
mode  in  2  pattern: 0 = word counter, 1 = LFSR, 2 = constant const_word, 3 = reserved (behaves as 0).
const_word  in  32  payload value for mode 2.
pkt_size  in  CNT_WIDTH  words per packet; 0 treated as 1.
pause_size  in  CNT_WIDTH  idle cycles between packets; 0 = back-to-back.
pkt_num  in  CNT_WIDTH  packets per run; 0 = continuous while start held.
mac_tx_data  out  TEST_DATA_WIDTH  payload word.
mac_tx_valid  out  1  word valid.
mac_tx_sof  out  1  first word of packet.
mac_tx_eof  out  1  last word of packet.
mac_tx_ready  in  1  sink accepts word when valid & ready.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse when a counted run (pkt_num != 0) completes.
pkt_cnt  out  CNT_WIDTH  packets fully accepted since last run start; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: all outputs 0, pkt_cnt 0, LFSR = LFSR_SEED, FSM = IDLE. Reset mid-packet aborts at that edge; no eof is emitted.
- States: IDLE, TX, PAUSE.
- IDLE -> TX: when start = 1.
  - Latch mode, const_word, pkt_size, pause_size, pkt_num.
  - Clear pkt_cnt and reload the LFSR.
  - Next cycle: valid = 1, sof = 1. Latency start -> first valid = 1 cycle.
  - Inputs are re-latched only at this transition; changes during a run are ignored.
- TX, word handshake:
  - A word is accepted on cycles where valid & ready.
  - While ready = 0, data, sof and eof are held stable and valid stays 1.
  - Word index w advances only on acceptance.
  - sof = 1 while w = 0; eof = 1 while w = pkt_size-1. pkt_size = 1 gives sof and eof on the same word.
- TX, payload (32-bit pattern word P):
  - Mode 0: P = w zero-extended.
  - Mode 1: P = LFSR state. LFSR is 32-bit Fibonacci x^32+x^22+x^2+x+1. It steps once per accepted word and reloads LFSR_SEED at every sof, so all packets are identical.
  - Mode 2: P = const_word.
  - mac_tx_data is P replicated from bit 0 upward and truncated to TEST_DATA_WIDTH.
- End of packet (eof accepted): pkt_cnt increments. Then:
  - If pkt_num != 0 and pkt_cnt+1 == pkt_num: pulse done, go to IDLE with valid = 0.
  - Else if pkt_num == 0 and start = 0: go to IDLE.
  - Else if pause_size = 0: valid stays 1 and the next cycle carries the next sof (no bubble).
  - Else: go to PAUSE with valid = 0.
- Packets are never truncated. Dropping start mid-packet finishes the current packet.
- PAUSE: count pause_size cycles.
  - At the end, re-evaluate start (continuous mode only): TX with next sof, or IDLE.
  - In counted mode, start is ignored after the run begins.
- done and busy: done asserts in the same cycle busy falls. Back-to-back runs are allowed: start held in IDLE relaunches the cycle after done.

Optional Feature:
Macro TEST_TX_SEQNUM_EN.
- Defined: the sof word's low CNT_WIDTH bits carry pkt_cnt (the packet's sequence number, from 0). Upper bits keep the pattern. The LFSR still steps on that word.
- Undefined: the sof word is pure pattern.

Test Plan:
- Mode 0, pkt_size = 4, pause_size = 2, pkt_num = 3, ready = 1 -> three packets with data 0,1,2,3; sof on 0, eof on 3; 2 idle cycles between packets; done pulse after the third eof; pkt_cnt = 3.
- Mode 1, pkt_size = 8, width 64 -> each packet's first word = 64'h55AA55AA55AA55AA; both packets bit-identical against the reference LFSR model.
- Mode 2, const_word = 32'hDEADBEEF, ready toggled 1010..., pkt_size = 5 -> exactly 5 accepted words per packet; data/sof/eof stable while ready = 0.
- pkt_size = 1, pause_size = 0, pkt_num = 0, start held 10 cycles then dropped -> valid continuous, sof = eof = 1 on every word; stops cleanly after the current word, busy -> 0.
- Reset asserted at w = 2 of a 6-word packet -> next cycle all outputs 0, IDLE; a restart begins with sof and LFSR_SEED.
- With TEST_TX_SEQNUM_EN, pkt_num = 4, mode 0 -> sof words' low 16 bits = 0, 1, 2, 3.

Source files
------------

// File: rtl/test_tx_gen.sv
// test_tx_gen: framed test packet source (counter / LFSR / constant payload) with backpressure and run control.
// Optional: define TEST_TX_SEQNUM_EN to stamp the packet sequence number into the low CNT_WIDTH bits of each sof word.
module test_tx_gen #(
  parameter int          TEST_DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_SEED       = 32'h55AA55AA,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [31:0]                const_word,
  input  logic [CNT_WIDTH-1:0]       pkt_size,
  input  logic [CNT_WIDTH-1:0]       pause_size,
  input  logic [CNT_WIDTH-1:0]       pkt_num,
  output logic [TEST_DATA_WIDTH-1:0] mac_tx_data,
  output logic                       mac_tx_valid,
  output logic                       mac_tx_sof,
  output logic                       mac_tx_eof,
  input  logic                       mac_tx_ready,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       pkt_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TX = 2'd1, S_PAUSE = 2'd2} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Fibonacci taps for x^32 + x^22 + x^2 + x + 1, shifting towards the MSB.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [TEST_DATA_WIDTH-1:0] make_word(
    input logic [1:0]           m,
    input logic [31:0]          cw,
    input logic [CNT_WIDTH-1:0] w,
    input logic [31:0]          lfsr
  );
    logic [31:0]                p;
    logic [TEST_DATA_WIDTH-1:0] d;
    case (m)
      2'd1:    p = lfsr;
      2'd2:    p = cw;
      default: p = 32'(w);
    endcase
    for (int i = 0; i < TEST_DATA_WIDTH; i++) begin
      d[i] = p[i % 32];
    end
    return d;
  endfunction

  state_t                     r_state;
  logic [1:0]                 r_mode;
  logic [31:0]                r_const;
  logic [CNT_WIDTH-1:0]       r_size;
  logic [CNT_WIDTH-1:0]       r_pause_len;
  logic [CNT_WIDTH-1:0]       r_num;
  logic [CNT_WIDTH-1:0]       r_w;
  logic [CNT_WIDTH-1:0]       r_pause_cnt;
  logic [CNT_WIDTH-1:0]       r_pkt_cnt;
  logic [31:0]                r_lfsr;
  logic [TEST_DATA_WIDTH-1:0] r_data;
  logic                       r_valid;
  logic                       r_sof;
  logic                       r_eof;
  logic                       r_busy;
  logic                       r_done;

  logic                       w_accept;
  logic                       w_eop;
  logic [CNT_WIDTH-1:0]       w_cnt_inc;
  logic                       w_last_pkt;
  logic                       w_launch;
  logic                       w_end_run;
  logic                       w_enter_pause;
  logic                       w_done_pulse;
  logic [CNT_WIDTH-1:0]       w_size_in;
  logic [CNT_WIDTH-1:0]       w_launch_size;
  logic [1:0]                 w_launch_mode;
  logic [31:0]                w_launch_const;
  logic [TEST_DATA_WIDTH-1:0] w_sof_word;
`ifdef TEST_TX_SEQNUM_EN
  localparam int SEQ_BITS = (CNT_WIDTH < TEST_DATA_WIDTH) ? CNT_WIDTH : TEST_DATA_WIDTH;
  logic [CNT_WIDTH-1:0]       w_launch_seq;
`endif

  // Transition decisions and the first word of the packet about to start.
  always_comb begin
    w_accept      = r_valid & mac_tx_ready;
    w_eop         = (r_state == S_TX) && w_accept && r_eof;
    w_cnt_inc     = r_pkt_cnt + CNT_ONE;
    w_last_pkt    = (r_num != '0) && (w_cnt_inc == r_num);
    w_done_pulse  = w_eop && w_last_pkt;
    w_launch      = 1'b0;
    w_end_run     = 1'b0;
    w_enter_pause = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_launch = start;
      end
      S_TX: begin
        if (w_eop) begin
          if (w_last_pkt) begin
            w_end_run = 1'b1;
          end else if ((r_num == '0) && !start) begin
            w_end_run = 1'b1;
          end else if (r_pause_len == '0) begin
            w_launch = 1'b1;
          end else begin
            w_enter_pause = 1'b1;
          end
        end else begin
          w_launch = 1'b0;
        end
      end
      S_PAUSE: begin
        if (r_pause_cnt == '0) begin
          if ((r_num != '0) || start) begin
            w_launch = 1'b1;
          end else begin
            w_end_run = 1'b1;
          end
        end else begin
          w_launch = 1'b0;
        end
      end
      default: begin
        w_end_run = 1'b1;
      end
    endcase

    w_size_in      = (pkt_size == '0) ? CNT_ONE : pkt_size;
    w_launch_size  = (r_state == S_IDLE) ? w_size_in  : r_size;
    w_launch_mode  = (r_state == S_IDLE) ? mode       : r_mode;
    w_launch_const = (r_state == S_IDLE) ? const_word : r_const;
    w_sof_word     = make_word(w_launch_mode, w_launch_const, '0, LFSR_SEED);
`ifdef TEST_TX_SEQNUM_EN
    // The sequence number is the count of packets completed before this one.
    case (r_state)
      S_IDLE:  w_launch_seq = '0;
      S_PAUSE: w_launch_seq = r_pkt_cnt;
      default: w_launch_seq = w_cnt_inc;
    endcase
    for (int i = 0; i < SEQ_BITS; i++) begin
      w_sof_word[i] = w_launch_seq[i];
    end
`endif
  end

  // Packet FSM with registered framing, payload and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_const     <= 32'd0;
      r_size      <= CNT_ONE;
      r_pause_len <= '0;
      r_num       <= '0;
      r_w         <= '0;
      r_pause_cnt <= '0;
      r_pkt_cnt   <= '0;
      r_lfsr      <= LFSR_SEED;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_pulse;

      if ((r_state == S_IDLE) && start) begin
        r_mode      <= mode;
        r_const     <= const_word;
        r_size      <= w_size_in;
        r_pause_len <= pause_size;
        r_num       <= pkt_num;
        r_pkt_cnt   <= '0;
      end else if (w_eop) begin
        r_pkt_cnt <= w_cnt_inc;
      end else begin
        r_pkt_cnt <= r_pkt_cnt;
      end

      if (w_launch) begin
        r_state <= S_TX;
        r_busy  <= 1'b1;
        r_valid <= 1'b1;
        r_sof   <= 1'b1;
        r_eof   <= (w_launch_size == CNT_ONE);
        r_w     <= '0;
        r_lfsr  <= LFSR_SEED;
        r_data  <= w_sof_word;
      end else if (w_end_run) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
        r_sof   <= 1'b0;
        r_eof   <= 1'b0;
      end else if (w_enter_pause) begin
        r_state     <= S_PAUSE;
        r_valid     <= 1'b0;
        r_sof       <= 1'b0;
        r_eof       <= 1'b0;
        r_pause_cnt <= r_pause_len - CNT_ONE;
      end else if (r_state == S_PAUSE) begin
        r_pause_cnt <= r_pause_cnt - CNT_ONE;
      end else if ((r_state == S_TX) && w_accept) begin
        // Mid-packet advance; a stalled word is simply held.
        r_w    <= r_w + CNT_ONE;
        r_lfsr <= lfsr_step(r_lfsr);
        r_data <= make_word(r_mode, r_const, r_w + CNT_ONE, lfsr_step(r_lfsr));
        r_sof  <= 1'b0;
        r_eof  <= ((r_w + CNT_ONE) == (r_size - CNT_ONE));
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign mac_tx_data  = r_data;
  assign mac_tx_valid = r_valid;
  assign mac_tx_sof   = r_sof;
  assign mac_tx_eof   = r_eof;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pkt_cnt      = r_pkt_cnt;

endmodule

// File: tb/tb_test_tx_gen.sv
// Directed bench for test_tx_gen: expected words are queued at launch and compared on every accepted word.
module tb_test_tx_gen;
  localparam int          DW   = 64;
  localparam int          CW   = 16;
  localparam logic [31:0] SEED = 32'h55AA55AA;

  logic          clk = 1'b0;
  logic          rst, start, ready;
  logic [1:0]    mode;
  logic [31:0]   cword;
  logic [CW-1:0] psize, pause, pnum;
  logic [DW-1:0] data;
  logic          valid, sof, eof, busy, done;
  logic [CW-1:0] pcnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_acc    = 0;
  bit          tog      = 1'b0;
  logic [65:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [65:0] prev_obs   = '0;

  always #5 clk = ~clk;

  test_tx_gen #(.TEST_DATA_WIDTH(DW), .LFSR_SEED(SEED), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .const_word(cword),
    .pkt_size(psize), .pause_size(pause), .pkt_num(pnum),
    .mac_tx_data(data), .mac_tx_valid(valid), .mac_tx_sof(sof), .mac_tx_eof(eof),
    .mac_tx_ready(ready), .busy(busy), .done(done), .pkt_cnt(pcnt)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Queue {sof, eof, data} for npk packets of size words each.
  task automatic push_pkts(input logic [1:0] m, input logic [31:0] cw, input int size, input int npk);
    logic [31:0] lf, p;
    logic [63:0] d;
    for (int k = 0; k < npk; k++) begin
      lf = SEED;
      for (int w = 0; w < size; w++) begin
        if (m == 2'd1)      p = lf;
        else if (m == 2'd2) p = cw;
        else                p = 32'(w);
        d = {p, p};
`ifdef TEST_TX_SEQNUM_EN
        if (w == 0) d[15:0] = 16'(k);
`endif
        exp_q.push_back({(w == 0), (w == size - 1), d});
        lf = lfsr_next(lf);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) ready = ~ready;
  endtask

  task automatic run_until_done(input int budget, input string tag, output int vcyc, output int gaps);
    bit seen;
    seen = 1'b0; vcyc = 0; gaps = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
      else begin
        if (valid) vcyc++;
        if (busy && !valid) gaps++;
      end
    end
    chk(tag, seen, 1'b1);
  endtask

  // Scoreboard monitor: pop on every handshake, and check words held stable across a stall.
  always @(negedge clk) begin
    logic [65:0] obs, e;
    obs = {sof, eof, data};
    if (prev_stall) begin
      chk("stall_valid", valid, 1'b1);
      chk("stall_word", obs, prev_obs);
    end
    if (valid && ready) begin
      n_acc++;
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_word", obs, e);
      end
    end
    prev_stall = valid && !ready && !rst;
    prev_obs   = obs;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vc, gp, acc0;
    logic [63:0] exp_first;
    logic [31:0] lf2;
    exp_first = {SEED, SEED};
`ifdef TEST_TX_SEQNUM_EN
    exp_first[15:0] = 16'h0000;
`endif
    rst = 1'b1; start = 1'b0; ready = 1'b1; mode = 2'd0; cword = 32'd0;
    psize = 16'd4; pause = 16'd2; pnum = 16'd3;
    step(); step(); step();
    chk("rst_flags", {valid, sof, eof, busy, done}, 5'b00000);
    chk("rst_data", data, 64'd0);
    chk("rst_cnt", pcnt, 16'd0);
    rst = 1'b0;
    step();

    // Counted run, counter pattern, pauses between packets; start dropped early.
    push_pkts(2'd0, 32'd0, 4, 3);
    start = 1'b1;
    chk("lat_pre_valid", valid, 1'b0);
    step();
    chk("lat_first", {valid, sof, eof, busy}, 4'b1101);
    start = 1'b0;
    run_until_done(60, "t1_done_seen", vc, gp);
    chk("t1_valid_cycles", vc, 11);
    chk("t1_gap_cycles", gp, 4);
    chk("t1_busy_at_done", busy, 1'b0);
    chk("t1_pkt_cnt", pcnt, 16'd3);
    step();
    chk("t1_done_pulse", {done, busy}, 2'b00);
    chk("t1_cnt_hold", pcnt, 16'd3);

    // LFSR pattern, back-to-back packets.
    mode = 2'd1; psize = 16'd8; pause = 16'd0; pnum = 16'd2;
    push_pkts(2'd1, 32'd0, 8, 2);
    start = 1'b1;
    step();
    chk("t2_first_word", {sof, data}, {1'b1, exp_first});
    start = 1'b0;
    run_until_done(60, "t2_done_seen", vc, gp);
    chk("t2_valid_cycles", vc, 15);
    chk("t2_gap_cycles", gp, 0);
    chk("t2_pkt_cnt", pcnt, 16'd2);

    // Reserved mode acts as counter; size 0 acts as 1.
    mode = 2'd3; psize = 16'd0; pnum = 16'd2;
    push_pkts(2'd0, 32'd0, 1, 2);
    start = 1'b1;
    step();
    chk("t3_sof_eof", {valid, sof, eof}, 3'b111);
    start = 1'b0;
    run_until_done(20, "t3_done_seen", vc, gp);
    chk("t3_valid_cycles", vc, 1);

    // Constant pattern with toggling ready.
    mode = 2'd2; cword = 32'hDEADBEEF; psize = 16'd5; pause = 16'd1; pnum = 16'd2;
    push_pkts(2'd2, 32'hDEADBEEF, 5, 2);
    acc0 = n_acc;
    tog = 1'b1; ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_until_done(80, "t4_done_seen", vc, gp);
    chk("t4_accepted", n_acc - acc0, 10);
    tog = 1'b0; ready = 1'b1;

    // Continuous single-word packets while start is held.
    mode = 2'd0; psize = 16'd1; pause = 16'd0; pnum = 16'd0;
    push_pkts(2'd0, 32'd0, 1, 10);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_cont", {valid, sof, eof}, 3'b111);
    end
    start = 1'b0;
    step();
    chk("t5_stop", {valid, busy, done}, 3'b000);
    chk("t5_pkt_cnt", pcnt, 16'd10);
    chk("t5_drained", exp_q.size(), 0);

    // Reset in the middle of a 6-word LFSR packet, then restart.
    mode = 2'd1; psize = 16'd6; pause = 16'd0; pnum = 16'd1;
    push_pkts(2'd1, 32'd0, 6, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    lf2 = lfsr_next(lfsr_next(SEED));
    chk("t6_w2_word", {valid, sof, eof, data[62:0]}, {3'b100, lf2[30:0], lf2});
    rst = 1'b1; ready = 1'b0;
    step();
    chk("t6_rst_flags", {valid, sof, eof, busy, done}, 5'b00000);
    chk("t6_rst_data", data, 64'd0);
    chk("t6_rst_q_left", exp_q.size(), 4);
    exp_q.delete();
    rst = 1'b0; ready = 1'b1;
    step();
    push_pkts(2'd1, 32'd0, 6, 1);
    start = 1'b1;
    step();
    chk("t6_restart_word", {sof, data}, {1'b1, exp_first});
    start = 1'b0;
    run_until_done(30, "t6_done_seen", vc, gp);
    chk("t6_valid_cycles", vc, 5);

    // start held in IDLE relaunches right after done.
    mode = 2'd0; psize = 16'd2; pnum = 16'd1;
    push_pkts(2'd0, 32'd0, 2, 1);
    push_pkts(2'd0, 32'd0, 2, 1);
    start = 1'b1;
    step(); step(); step();
    chk("t7_done", {done, busy}, 2'b10);
    chk("t7_cnt_at_done", pcnt, 16'd1);
    step();
    chk("t7_relaunch", {valid, sof, busy, done}, 4'b1110);
    chk("t7_cnt_cleared", pcnt, 16'd0);
    start = 1'b0;
    run_until_done(20, "t7_done_seen", vc, gp);
    chk("t7_valid_cycles", vc, 1);
    step();
    chk("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
